pll_supervisor: RTL and testbench
=================================

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4800, giving the number of clk_48mhz cycles that synchronized lock must hold before system reset is released.
REQ-002 The block SHALL have parameter EXPECT_CYCLES, default 4096, giving the nominal number of clk_48mhz cycles between ref_toggle edges.
REQ-003 The block SHALL have parameter TOL_CYCLES, default 8, giving the allowed deviation from EXPECT_CYCLES.
REQ-004 The block SHALL have port clk_48mhz, input, 1 bit: the single clock (PLL core output); all logic is clocked on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port locked, input, 1 bit: asynchronous PLL lock indication.
REQ-007 The block SHALL have port ref_toggle, input, 1 bit: asynchronous reference that toggles every 1024 periods of the 12 MHz reference clock.
REQ-008 The block SHALL have port sys_rst, output, 1 bit: active-high system reset for downstream logic.
REQ-009 The block SHALL have port ready, output, 1 bit: clock qualified and in use.
REQ-010 The block SHALL have port freq_err, output, 1 bit: last measured interval was out of tolerance, or a reference edge is missing.
REQ-011 The block SHALL have port interval, output, 16 bits: last measured cycle count between reference edges.
REQ-012 The block SHALL have port lock_lost_count, output, 8 bits: number of lock losses while in RUN.

Function
REQ-013 locked and ref_toggle SHALL each pass through a two-flop synchronizer before any use; lk_s and rt_s denote the synchronized values.
REQ-014 The FSM SHALL have exactly three states: WAIT, STABLE and RUN.
REQ-015 In WAIT: sys_rst=1 and ready=0; when lk_s=1 the FSM SHALL move to STABLE with the stable counter cleared.
REQ-016 In STABLE: the stable counter SHALL increment each cycle while lk_s=1.
REQ-017 In STABLE: lk_s=0 SHALL return the FSM to WAIT, with the counter cleared and lock_lost_count unchanged.
REQ-018 In STABLE: when the counter equals STABLE_CYCLES-1 and lk_s=1, the FSM SHALL move to RUN, so sys_rst falls exactly STABLE_CYCLES cycles after the first lk_s=1 cycle.
REQ-019 In RUN: sys_rst=0 and ready=1; lk_s=0 SHALL move the FSM to WAIT on the next edge and reassert sys_rst.
REQ-020 On that RUN-to-WAIT transition, lock_lost_count SHALL increment, saturating at 255.
REQ-021 A ref_toggle edge SHALL be detected as rt_s differing from its previous registered value, giving a one-cycle pulse.
REQ-022 The interval counter SHALL run only in RUN.
REQ-023 On the first edge after entering RUN, the interval counter SHALL be cleared and no measurement recorded, marking the measurement as armed.
REQ-024 On each later edge, interval SHALL be loaded with count+1 and the counter cleared.
REQ-025 On each later edge, freq_err SHALL be set to 1 if |count+1 - EXPECT_CYCLES| > TOL_CYCLES, else 0.
REQ-026 When armed with no edge and the counter reaches EXPECT_CYCLES+TOL_CYCLES+1, freq_err SHALL be set to 1.
REQ-027 After that timeout the counter SHALL keep counting, saturating at 16'hFFFF; a subsequent edge still loads interval and re-evaluates freq_err.
REQ-028 Entering WAIT SHALL clear freq_err and disarm the measurement; interval SHALL hold its last value.
REQ-029 The tolerance comparison SHALL use a width of at least 17 bits with no wrap; EXPECT_CYCLES+TOL_CYCLES SHALL be at most 65534.
REQ-030 If a lock loss and a reference edge occur in the same RUN cycle, the lock loss SHALL win: the FSM goes to WAIT, the edge is discarded and interval is not updated.
REQ-031 freq_err SHALL be informational only and SHALL NOT affect sys_rst or the FSM.

Reset
REQ-032 When reset=1 on a clock edge, the block SHALL set: state=WAIT, sys_rst=1, ready=0, freq_err=0, interval=0, lock_lost_count=0, all counters=0, measurement disarmed.
REQ-033 When reset=1 on a clock edge, the synchronizer flops SHALL be set to 0.
REQ-034 reset asserted mid-operation, in any state, SHALL take effect on the next edge and override all other events.
REQ-035 Outputs SHALL be driven by registers only.

Verification
REQ-036 Lock-up: reset then locked=1 constant, STABLE_CYCLES=16 -> sys_rst falls and ready rises exactly 2+16 cycles after locked rises, and lock_lost_count=0.
REQ-037 Glitch during STABLE: locked low for 3 cycles at stable count 10 -> FSM returns to WAIT, lock_lost_count stays 0, and the full 16-cycle count restarts after relock.
REQ-038 Nominal frequency: in RUN, ref_toggle toggles every 4096 cycles -> first edge is discarded, then interval=4096 and freq_err=0 on each later edge.
REQ-039 Out of tolerance: toggling every 4105 cycles sets freq_err=1 and interval=4105; toggling every 4104 cycles gives freq_err=0. With toggling stopped, freq_err=1 exactly 4105 cycles after the last edge.
REQ-040 Lock loss in RUN: locked drops 300 times -> sys_rst reasserts each time and lock_lost_count saturates at 255. A coincident ref edge and lock loss leave interval unchanged.
REQ-041 Reset mid-RUN: reset=1 for 1 cycle -> all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/pll_supervisor.sv
// Supervises the 48 MHz PLL: holds sys_rst until lock has been stable, then
// measures the clock against a slow reference toggle and counts lock losses.
module pll_supervisor #(
    parameter int STABLE_CYCLES = 4800,
    parameter int EXPECT_CYCLES = 4096,
    parameter int TOL_CYCLES    = 8
) (
    input  logic        clk_48mhz,
    input  logic        reset,
    input  logic        locked,
    input  logic        ref_toggle,
    output logic        sys_rst,
    output logic        ready,
    output logic        freq_err,
    output logic [15:0] interval,
    output logic [7:0]  lock_lost_count
);

    localparam int SC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SC_W-1:0]   STABLE_LAST  = SC_W'(STABLE_CYCLES - 1);
    localparam logic [15:0]       TIMEOUT_PREV = 16'(EXPECT_CYCLES + TOL_CYCLES);
    localparam logic signed [17:0] EXPECT_S    = 18'(EXPECT_CYCLES);
    localparam logic signed [17:0] TOL_S       = 18'(TOL_CYCLES);

    typedef enum logic [1:0] {ST_WAIT, ST_STABLE, ST_RUN} state_t;

    state_t          state_q;
    logic            lk_meta_q, lk_s_q;
    logic            rt_meta_q, rt_s_q, rt_prev_q;
    logic [SC_W-1:0] stable_cnt_q;
    logic [15:0]     int_cnt_q;
    logic            armed_q;
    logic            sys_rst_q, ready_q, freq_err_q;
    logic [15:0]     interval_q;
    logic [7:0]      lost_q;

    logic            rt_edge_d;
    logic [16:0]     meas_d;
    logic            tol_err_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] sat_to16(input logic [16:0] v);
        return v[16] ? 16'hFFFF : v[15:0];
    endfunction

    // Signed 18-bit difference so the magnitude test cannot wrap.
    function automatic logic out_of_tol(input logic [16:0] meas);
        logic signed [17:0] diff;
        logic signed [17:0] mag;
        diff = $signed({1'b0, meas}) - EXPECT_S;
        mag  = (diff < 0) ? -diff : diff;
        return mag > TOL_S;
    endfunction

    assign rt_edge_d = rt_s_q ^ rt_prev_q;
    assign meas_d    = {1'b0, int_cnt_q} + 17'd1;
    assign tol_err_d = out_of_tol(meas_d);

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q      <= ST_WAIT;
            lk_meta_q    <= 1'b0;
            lk_s_q       <= 1'b0;
            rt_meta_q    <= 1'b0;
            rt_s_q       <= 1'b0;
            rt_prev_q    <= 1'b0;
            stable_cnt_q <= '0;
            int_cnt_q    <= '0;
            armed_q      <= 1'b0;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            freq_err_q   <= 1'b0;
            interval_q   <= '0;
            lost_q       <= '0;
        end else begin
            lk_meta_q <= locked;
            lk_s_q    <= lk_meta_q;
            rt_meta_q <= ref_toggle;
            rt_s_q    <= rt_meta_q;
            rt_prev_q <= rt_s_q;

            case (state_q)
                ST_WAIT: begin
                    sys_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                    if (lk_s_q) begin
                        state_q      <= ST_STABLE;
                        stable_cnt_q <= '0;
                    end
                end
                ST_STABLE: begin
                    if (!lk_s_q) begin
                        state_q      <= ST_WAIT;
                        stable_cnt_q <= '0;
                    end else if (stable_cnt_q == STABLE_LAST) begin
                        state_q      <= ST_RUN;
                        stable_cnt_q <= '0;
                        sys_rst_q    <= 1'b0;
                        ready_q      <= 1'b1;
                    end else begin
                        stable_cnt_q <= stable_cnt_q + SC_W'(1);
                    end
                end
                ST_RUN: begin
                    // Lock loss outranks a coincident reference edge.
                    if (!lk_s_q) begin
                        state_q    <= ST_WAIT;
                        sys_rst_q  <= 1'b1;
                        ready_q    <= 1'b0;
                        lost_q     <= sat_inc8(lost_q);
                        freq_err_q <= 1'b0;
                        armed_q    <= 1'b0;
                        int_cnt_q  <= '0;
                    end else if (rt_edge_d) begin
                        int_cnt_q <= '0;
                        armed_q   <= 1'b1;
                        if (armed_q) begin
                            interval_q <= sat_to16(meas_d);
                            freq_err_q <= tol_err_d;
                        end
                    end else begin
                        int_cnt_q <= sat_inc16(int_cnt_q);
                        if (armed_q && int_cnt_q == TIMEOUT_PREV) begin
                            freq_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_WAIT;
            endcase
        end
    end

    assign sys_rst         = sys_rst_q;
    assign ready           = ready_q;
    assign freq_err        = freq_err_q;
    assign interval        = interval_q;
    assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboard bench for pll_supervisor: stimulus schedules expected output
// snapshots by cycle number; a negedge monitor pops and compares them.
module tb_pll_supervisor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        locked = 1'b0;
    logic        ref_toggle = 1'b0;
    logic        sys_rst, ready, freq_err;
    logic [15:0] interval;
    logic [7:0]  lock_lost_count;

    pll_supervisor #(
        .STABLE_CYCLES(16),
        .EXPECT_CYCLES(4096),
        .TOL_CYCLES   (8)
    ) dut (
        .clk_48mhz      (clk),
        .reset          (reset),
        .locked         (locked),
        .ref_toggle     (ref_toggle),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .freq_err       (freq_err),
        .interval       (interval),
        .lock_lost_count(lock_lost_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       nm;
        logic        sr;
        logic        rdy;
        logic        fe;
        logic [15:0] iv;
        logic [7:0]  ll;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int c, input string nm, input logic sr, input logic rdy,
                             input logic fe, input logic [15:0] iv, input logic [7:0] ll);
        exp_t e;
        e.cyc = c; e.nm = nm; e.sr = sr; e.rdy = rdy; e.fe = fe; e.iv = iv; e.ll = ll;
        sbq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every snapshot that falls due on this cycle.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            mon_e = sbq.pop_front();
            checks++;
            if (mon_e.cyc != cyc ||
                {sys_rst, ready, freq_err, interval, lock_lost_count} !==
                {mon_e.sr, mon_e.rdy, mon_e.fe, mon_e.iv, mon_e.ll}) begin
                errors++;
                $display("FAIL %s cycle %0d (due %0d): got sr=%0b rdy=%0b fe=%0b iv=%0d llc=%0d, expected sr=%0b rdy=%0b fe=%0b iv=%0d llc=%0d",
                         mon_e.nm, cyc, mon_e.cyc, sys_rst, ready, freq_err, interval,
                         lock_lost_count, mon_e.sr, mon_e.rdy, mon_e.fe, mon_e.iv, mon_e.ll);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int          per_tbl [5] = '{4096, 4096, 4105, 4104, 4096};
    logic        fe_tbl  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int          c, tp, lst, d, r, rr;
    logic        prev_fe;
    logic [15:0] prev_iv;
    logic [7:0]  ll_exp;

    initial begin
        // Reset and idle WAIT
        step(3);
        checks++;
        if (sys_rst !== 1'b1) begin
            errors++;
            $display("FAIL reset_direct_sr: got %0b", sys_rst);
        end
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_direct_rdy: got %0b", ready);
        end
        checks++;
        if (freq_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_direct_fe: got %0b", freq_err);
        end
        checks++;
        if (interval !== 16'd0) begin
            errors++;
            $display("FAIL reset_direct_iv: got %0d", interval);
        end
        checks++;
        if (lock_lost_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_direct_llc: got %0d", lock_lost_count);
        end
        expect_at(cyc, "reset_state", 1, 0, 0, 16'd0, 8'd0);
        reset = 1'b0;
        step(5);
        expect_at(cyc, "wait_idle", 1, 0, 0, 16'd0, 8'd0);

        // Lock-up: release 2 sync + 16 stable cycles after locked rises
        locked = 1'b1;
        c = cyc;
        expect_at(c + 18, "lockup_hold", 1, 0, 0, 16'd0, 8'd0);
        expect_at(c + 19, "lockup_release", 0, 1, 0, 16'd0, 8'd0);
        step(25);

        // First reference edge only arms the measurement
        ref_toggle = ~ref_toggle;
        tp = cyc;
        expect_at(tp + 3, "arm_discard", 0, 1, 0, 16'd0, 8'd0);
        prev_fe = 1'b0;
        prev_iv = 16'd0;
        for (int i = 0; i < 5; i++) begin
            step(per_tbl[i]);
            ref_toggle = ~ref_toggle;
            tp = cyc;
            expect_at(tp + 2, "pre_edge", 0, 1, prev_fe, prev_iv, 8'd0);
            expect_at(tp + 3, "edge_meas", 0, 1, fe_tbl[i], 16'(per_tbl[i]), 8'd0);
            prev_fe = fe_tbl[i];
            prev_iv = 16'(per_tbl[i]);
        end

        // Missing edge: timeout 4105 cycles after the last processed edge
        lst = tp + 3;
        expect_at(lst + 4104, "timeout_pre", 0, 1, 0, 16'd4096, 8'd0);
        expect_at(lst + 4105, "timeout", 0, 1, 1, 16'd4096, 8'd0);
        step(lst + 4997 - cyc);
        ref_toggle = ~ref_toggle;
        tp = cyc;
        expect_at(tp + 2, "late_pre", 0, 1, 1, 16'd4096, 8'd0);
        expect_at(tp + 3, "late_edge", 0, 1, 1, 16'd5000, 8'd0);

        // Coincident edge and lock loss: edge discarded, interval kept
        step(1000);
        ref_toggle = ~ref_toggle;
        locked = 1'b0;
        tp = cyc;
        expect_at(tp + 2, "coinc_pre", 0, 1, 1, 16'd5000, 8'd0);
        expect_at(tp + 3, "coinc_loss", 1, 0, 0, 16'd5000, 8'd1);
        step(5);

        // Repeated lock losses, counter saturates at 255
        for (int n = 2; n <= 300; n++) begin
            locked = 1'b1;
            step(20);
            ll_exp = (n - 1 > 255) ? 8'd255 : 8'(n - 1);
            expect_at(cyc, "relock_run", 0, 1, 0, 16'd5000, ll_exp);
            locked = 1'b0;
            d = cyc;
            ll_exp = (n > 255) ? 8'd255 : 8'(n);
            expect_at(d + 3, "loss_wait", 1, 0, 0, 16'd5000, ll_exp);
            step(5);
        end

        // Reset in the middle of RUN
        locked = 1'b1;
        step(20);
        expect_at(cyc, "run_before_reset", 0, 1, 0, 16'd5000, 8'd255);
        reset = 1'b1;
        r = cyc;
        expect_at(r + 1, "midrun_reset", 1, 0, 0, 16'd0, 8'd0);
        step(1);
        reset = 1'b0;
        rr = cyc;

        // Glitch in STABLE at count 10: back to WAIT, full count restarts
        step(11);
        locked = 1'b0;
        expect_at(rr + 19, "glitch_no_early", 1, 0, 0, 16'd0, 8'd0);
        step(3);
        locked = 1'b1;
        expect_at(rr + 32, "glitch_hold", 1, 0, 0, 16'd0, 8'd0);
        expect_at(rr + 33, "glitch_release", 0, 1, 0, 16'd0, 8'd0);
        step(40);

        checks++;
        if (sys_rst !== 1'b0) begin
            errors++;
            $display("FAIL final_direct_sr: got %0b", sys_rst);
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL final_direct_rdy: got %0b", ready);
        end
        checks++;
        if (freq_err !== 1'b0) begin
            errors++;
            $display("FAIL final_direct_fe: got %0b", freq_err);
        end
        checks++;
        if (lock_lost_count !== 8'd0) begin
            errors++;
            $display("FAIL final_direct_llc: got %0d", lock_lost_count);
        end

        while (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never checked (due cycle %0d, now %0d)", mon_e.nm, mon_e.cyc, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
